bsg_manycore_host_timer_decoder: RTL
====================================

Name: bsg_manycore_host_timer_decoder

Overview:
- Host-side receiver for the manycore-to-host request stream after the endpoint timer stage.
- Recognises the two-beat timer packet: low word first, then high word, both carrying the timer address with we=1.
- Reassembles the two beats into a 64-bit timestamp and queues it, together with the source tile coordinates, in a small timestamp FIFO.
- All other request packets pass through unchanged to the host request channel via a one-entry output register.

Parameters:
- x_cord_width_p, "inv", tile X coordinate width.
- y_cord_width_p, "inv", tile Y coordinate width.
- addr_width_p, "inv", packet address width.
- data_width_p, "inv", packet data width; must be >= 32.
- timer_addr_p, 16'h3AB5, address identifying timer beats.
- ts_els_p, 4, timestamp FIFO depth; must be >= 2.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- v_i  in  1  upstream beat valid.
- ready_o  out  1  decoder can accept a beat.
- data_i  in  data_width_p  beat data.
- mask_i  in  data_width_p>>3  beat byte mask.
- addr_i  in  addr_width_p  beat address.
- we_i  in  1  beat write-enable.
- src_x_cord_i  in  x_cord_width_p  source X coordinate.
- src_y_cord_i  in  y_cord_width_p  source Y coordinate.
- v_o  out  1  bypass packet valid.
- yumi_i  in  1  host consumes bypass packet.
- data_o / mask_o / addr_o / we_o / src_x_cord_o / src_y_cord_o  out  same widths as the corresponding inputs  bypass packet fields.
- ts_v_o  out  1  timestamp available.
- ts_yumi_i  in  1  host consumes timestamp.
- ts_o  out  64  reassembled timestamp.
- ts_x_cord_o  out  x_cord_width_p  timestamp source X.
- ts_y_cord_o  out  y_cord_width_p  timestamp source Y.
- error_o  out  1  sticky protocol-error flag.

Behaviour:
- Clock and reset: single clock clk_i; reset_i is synchronous and active-high.
- Reset values: state=IDLE, bypass register empty (v_o=0), FIFO empty (ts_v_o=0), error_o=0, ready_o=1 on the first cycle after reset.
- Handshake:
  - A beat transfers when v_i & ready_o.
  - ready_o is a function of registered state only, never of v_i or addr_i. Upstream gates its valid with this ready, so there must be no combinational loop.
  - ready_o = ~bypass_full_r & (ts_count_r < ts_els_p).
- Timer beat: is_timer = (addr_i == timer_addr_p) & we_i. mask_i is ignored for classification.
- State machine:
  - IDLE:
    - Accepted timer beat: lo_r <= data_i[31:0]; capture src x/y; go to WAIT_HI.
    - Accepted non-timer beat: load the bypass register; stay in IDLE.
  - WAIT_HI:
    - Accepted timer beat: push {data_i[31:0], lo_r} with the captured coordinates into the FIFO; go to IDLE.
    - Accepted non-timer beat: set error_o; discard lo_r; load the beat into the bypass register; go to IDLE.
- Bypass register:
  - Fields are registered on load; v_o=1 while full.
  - yumi_i clears it. yumi_i is legal only while v_o=1.
  - Latency input-to-v_o is 1 cycle.
  - ready_o is 0 while full, so a new load and a yumi_i cannot occur in the same cycle.
- Timestamp FIFO:
  - Depth ts_els_p, first-in first-out; occupancy ts_count_r ranges 0..ts_els_p.
  - ts_o and the coordinates present the head entry.
  - Simultaneous push and pop (ts_yumi_i) leaves the count unchanged. Pop-while-empty cannot occur (ts_yumi_i requires ts_v_o).
  - Pointers wrap modulo ts_els_p.
  - Push-to-ts_v_o latency is 1 cycle after the high beat.
- Full FIFO: ready_o drops, including between the low and high beats, so a WAIT_HI high beat is never lost.
- error_o: sticky until reset.
- Reset mid-packet (WAIT_HI): the partial timestamp is dropped; no FIFO entry is produced.

Optional Feature:
- Macro: BSG_MANYCORE_HOST_TIMER_DECODER_DELTA_EN.
- Defined:
  - Adds output ts_delta_o (64 bits), stored per FIFO entry.
  - ts_delta_o = this timestamp minus the previously pushed timestamp, modulo 2^64.
  - The first timestamp after reset has delta 0.
  - The previous-timestamp register updates on push, not on pop.
- Undefined: no port, no delta storage, no subtractor.

Test Plan:
- Timer pair 32'h0000_0010 then 32'h0000_0001 from (x=2, y=3) -> one cycle later ts_v_o=1, ts_o=64'h0000_0001_0000_0010, coordinates (2,3); v_o never asserts.
- Non-timer write addr=16'h0100, data=32'hDEADBEEF, yumi_i held 0 for 5 cycles -> v_o=1 with fields unchanged, ready_o=0; after yumi_i, ready_o=1 on the next cycle.
- Timer low beat, then non-timer beat -> error_o=1 and remains 1; the non-timer packet appears on v_o; no timestamp is pushed.
- Push ts_els_p pairs with ts_yumi_i=0 -> ready_o=0 at count=4; one pop re-raises ready_o; entries drain in order with correct values across pointer wrap.
- Reset asserted in WAIT_HI, then a fresh pair 32'h5 / 32'h0 -> exactly one entry, 64'h5; error_o=0.
- DELTA_EN: timestamps 100, 350, 351 -> deltas 0, 250, 1; high-word carry case 64'h0_FFFF_FFFF to 64'h1_0000_0002 -> delta 3.

Source files
------------

// File: rtl/bsg_manycore_host_timer_decoder.sv
// rtl/bsg_manycore_host_timer_decoder.sv - manycore-to-host timer packet decoder with timestamp FIFO
// Optional macro: BSG_MANYCORE_HOST_TIMER_DECODER_DELTA_EN adds ts_delta_o (per-entry timestamp delta).
module bsg_manycore_host_timer_decoder #(
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 4,
  parameter int addr_width_p   = 16,
  parameter int data_width_p   = 32,
  parameter int timer_addr_p   = 'h3AB5,
  parameter int ts_els_p       = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          v_i,
  output logic                          ready_o,
  input  logic [data_width_p-1:0]       data_i,
  input  logic [(data_width_p>>3)-1:0]  mask_i,
  input  logic [addr_width_p-1:0]       addr_i,
  input  logic                          we_i,
  input  logic [x_cord_width_p-1:0]     src_x_cord_i,
  input  logic [y_cord_width_p-1:0]     src_y_cord_i,
  output logic                          v_o,
  input  logic                          yumi_i,
  output logic [data_width_p-1:0]       data_o,
  output logic [(data_width_p>>3)-1:0]  mask_o,
  output logic [addr_width_p-1:0]       addr_o,
  output logic                          we_o,
  output logic [x_cord_width_p-1:0]     src_x_cord_o,
  output logic [y_cord_width_p-1:0]     src_y_cord_o,
  output logic                          ts_v_o,
  input  logic                          ts_yumi_i,
  output logic [63:0]                   ts_o,
  output logic [x_cord_width_p-1:0]     ts_x_cord_o,
  output logic [y_cord_width_p-1:0]     ts_y_cord_o,
`ifdef BSG_MANYCORE_HOST_TIMER_DECODER_DELTA_EN
  output logic [63:0]                   ts_delta_o,
`endif
  output logic                          error_o
);

  localparam int ptr_w_lp  = (ts_els_p > 1) ? $clog2(ts_els_p) : 1;
  localparam int cnt_w_lp  = $clog2(ts_els_p + 1);
  localparam int mask_w_lp = data_width_p >> 3;
  localparam logic [cnt_w_lp-1:0] ts_els_lp  = cnt_w_lp'(ts_els_p);
  localparam logic [ptr_w_lp-1:0] ptr_max_lp = ptr_w_lp'(ts_els_p - 1);

  typedef enum logic {IDLE, WAIT_HI} state_e;

  state_e                      state_r;
  logic [31:0]                 lo_r;
  logic [x_cord_width_p-1:0]   cap_x_r;
  logic [y_cord_width_p-1:0]   cap_y_r;
  logic                        error_r;

  logic                        byp_full_r;
  logic [data_width_p-1:0]     byp_data_r;
  logic [mask_w_lp-1:0]        byp_mask_r;
  logic [addr_width_p-1:0]     byp_addr_r;
  logic                        byp_we_r;
  logic [x_cord_width_p-1:0]   byp_x_r;
  logic [y_cord_width_p-1:0]   byp_y_r;

  logic [63:0]                 ts_mem   [ts_els_p];
  logic [x_cord_width_p-1:0]   ts_x_mem [ts_els_p];
  logic [y_cord_width_p-1:0]   ts_y_mem [ts_els_p];
  logic [ptr_w_lp-1:0]         wptr_r, rptr_r;
  logic [cnt_w_lp-1:0]         ts_count_r;

  logic        accept, is_timer, push, pop, load_byp;
  logic [63:0] push_ts;

  // Ready depends only on registered occupancy so upstream valid can never loop back into it.
  assign ready_o  = ~byp_full_r & (ts_count_r < ts_els_lp);
  assign accept   = v_i & ready_o;
  assign is_timer = (addr_i == addr_width_p'(timer_addr_p)) & we_i;
  assign push     = accept & is_timer & (state_r == WAIT_HI);
  assign pop      = ts_yumi_i & ts_v_o;
  assign load_byp = accept & ~is_timer;
  assign push_ts  = {data_i[31:0], lo_r};

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_max_lp) ? '0 : p + 1'b1;
  endfunction

  // Two-beat timer packet assembly and sticky error on an interrupted pair.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      lo_r    <= '0;
      cap_x_r <= '0;
      cap_y_r <= '0;
      error_r <= 1'b0;
    end else if (accept) begin
      case (state_r)
        IDLE: begin
          if (is_timer) begin
            lo_r    <= data_i[31:0];
            cap_x_r <= src_x_cord_i;
            cap_y_r <= src_y_cord_i;
            state_r <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (!is_timer) error_r <= 1'b1;
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // One-entry bypass register for every non-timer beat.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      byp_full_r <= 1'b0;
      byp_data_r <= '0;
      byp_mask_r <= '0;
      byp_addr_r <= '0;
      byp_we_r   <= 1'b0;
      byp_x_r    <= '0;
      byp_y_r    <= '0;
    end else if (load_byp) begin
      byp_full_r <= 1'b1;
      byp_data_r <= data_i;
      byp_mask_r <= mask_i;
      byp_addr_r <= addr_i;
      byp_we_r   <= we_i;
      byp_x_r    <= src_x_cord_i;
      byp_y_r    <= src_y_cord_i;
    end else if (yumi_i) begin
      byp_full_r <= 1'b0;
    end
  end

  // Timestamp FIFO storage and pointers; a push is only possible when not full.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_r     <= '0;
      rptr_r     <= '0;
      ts_count_r <= '0;
    end else begin
      if (push) begin
        ts_mem[wptr_r]   <= push_ts;
        ts_x_mem[wptr_r] <= cap_x_r;
        ts_y_mem[wptr_r] <= cap_y_r;
        wptr_r           <= ptr_inc(wptr_r);
      end
      if (pop) rptr_r <= ptr_inc(rptr_r);
      if (push && !pop)      ts_count_r <= ts_count_r + 1'b1;
      else if (pop && !push) ts_count_r <= ts_count_r - 1'b1;
    end
  end

`ifdef BSG_MANYCORE_HOST_TIMER_DECODER_DELTA_EN
  logic [63:0] prev_ts_r;
  logic        prev_v_r;
  logic [63:0] delta_mem [ts_els_p];

  // Delta against the previously pushed timestamp; the first one after reset reports zero.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prev_ts_r <= '0;
      prev_v_r  <= 1'b0;
    end else if (push) begin
      delta_mem[wptr_r] <= prev_v_r ? (push_ts - prev_ts_r) : 64'd0;
      prev_ts_r         <= push_ts;
      prev_v_r          <= 1'b1;
    end
  end

  assign ts_delta_o = delta_mem[rptr_r];
`endif

  assign v_o          = byp_full_r;
  assign data_o       = byp_data_r;
  assign mask_o       = byp_mask_r;
  assign addr_o       = byp_addr_r;
  assign we_o         = byp_we_r;
  assign src_x_cord_o = byp_x_r;
  assign src_y_cord_o = byp_y_r;

  assign ts_v_o       = (ts_count_r != '0);
  assign ts_o         = ts_mem[rptr_r];
  assign ts_x_cord_o  = ts_x_mem[rptr_r];
  assign ts_y_cord_o  = ts_y_mem[rptr_r];
  assign error_o      = error_r;

endmodule
